// File: rtl/draw_circles_pkg.sv
// Shared definitions for the circle renderer: colour constants, mode
// encoding and small width/slice helpers used by the top and the per-object
// distance pipeline.
package draw_pkg;

   // Colour shown when no object covers the pixel
   localparam int NULL_COLOR = 0;

   // Mode value that selects per-object colours
   localparam logic MODE_LIMITED = 1'b1;

   // Colour used for every object when mode is not LIMITED
   localparam logic [11:0] DEFAULT_SCORE_COLOR = 12'hF80;

   // Index width for n objects, never narrower than one bit
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   // Low bit of element idx in a flat bus of w-bit elements
   function automatic int slice_lsb(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/draw_circles_circle_hit_pipe.sv
// Single-object distance pipeline: S1 computes the pixel-to-centre deltas,
// S2 squares them, and the S3 compare is presented combinationally so the
// top can register the priority result. Optional macro DRAW_CIRCLES_RING_EN
// turns the filled disk into a ring of width RING_W.
module circle_hit_pipe
   import draw_pkg::*;
#(
   parameter int COORD_W  = 11,
   parameter int RADIUS_W = 7
`ifdef DRAW_CIRCLES_RING_EN
   ,
   parameter int RING_W   = 3
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s0_valid_i,
   input  logic                s1_valid_i,
   input  logic [COORD_W-1:0]  x_i,
   input  logic [COORD_W-1:0]  y_i,
   input  logic [COORD_W-1:0]  ox_i,
   input  logic [COORD_W-1:0]  oy_i,
   input  logic [RADIUS_W-1:0] r_i,
   input  logic                en_i,
   output logic                in_o
);

   localparam int SQ_W  = 2 * COORD_W;
   localparam int R2_W  = 2 * RADIUS_W;
   localparam int CMP_W = (SQ_W > R2_W) ? SQ_W : R2_W;

   logic signed [COORD_W-1:0] dx_d, dy_d, dx_q, dy_q;
   logic                      off_d, off1_q, en1_q;
   logic [RADIUS_W-1:0]       r1_q;
   logic [COORD_W-1:0]        adx, ady;
   logic [SQ_W-1:0]           d2_d, d2_q;
   logic [R2_W-1:0]           r2_d, r2_q;
   logic                      off2_q, en2_q;
   logic                      ring_ok;

   // The object's own MSB (blank marker) does not take part in the distance test
   logic unused_obj_msb;
   assign unused_obj_msb = ox_i[COORD_W-1] ^ oy_i[COORD_W-1];

   // S1 combinational deltas on the low coordinate bits
   always_comb begin
      // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
      dx_d  = $signed({1'b0, x_i[COORD_W-2:0]} - {1'b0, ox_i[COORD_W-2:0]});
      dy_d  = $signed({1'b0, y_i[COORD_W-2:0]} - {1'b0, oy_i[COORD_W-2:0]});
      off_d = x_i[COORD_W-1] | y_i[COORD_W-1];
   end

   // S1 register: deltas, off-screen flag and the object's radius/enable
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: datapath registers are reset too, so no X ever reaches the outputs after reset.
      if (rst) begin
         dx_q   <= '0;
         dy_q   <= '0;
         off1_q <= 1'b0;
         en1_q  <= 1'b0;
         r1_q   <= '0;
      end else if (s0_valid_i) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         dx_q   <= dx_d;
         dy_q   <= dy_d;
         off1_q <= off_d;
         en1_q  <= en_i;
         r1_q   <= r_i;
      end
   end

   // S2 combinational squares; magnitudes keep the products unsigned and exact
   always_comb begin
      adx  = dx_q[COORD_W-1] ? $unsigned(-dx_q) : $unsigned(dx_q);
      ady  = dy_q[COORD_W-1] ? $unsigned(-dy_q) : $unsigned(dy_q);
      d2_d = SQ_W'(adx) * SQ_W'(adx) + SQ_W'(ady) * SQ_W'(ady);
      r2_d = R2_W'(r1_q) * R2_W'(r1_q);
   end

`ifdef DRAW_CIRCLES_RING_EN
   logic [RADIUS_W-1:0] inner_r;
   logic [R2_W-1:0]     ri2_d, ri2_q;
   logic                filled_d, filled_q;

   // S2 inner-radius square; small radii degrade to a filled disk
   always_comb begin
      filled_d = (r1_q <= RADIUS_W'(RING_W));
      inner_r  = filled_d ? '0 : r1_q - RADIUS_W'(RING_W);
      ri2_d    = R2_W'(inner_r) * R2_W'(inner_r);
   end

   // S2 register for the ring bound
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ri2_q    <= '0;
         filled_q <= 1'b0;
      end else if (s1_valid_i) begin
         ri2_q    <= ri2_d;
         filled_q <= filled_d;
      end
   end

   assign ring_ok = filled_q | (CMP_W'(d2_q) > CMP_W'(ri2_q));
`else
   assign ring_ok = 1'b1;
`endif

   // S2 register: squared distance and squared radius
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d2_q   <= '0;
         r2_q   <= '0;
         off2_q <= 1'b0;
         en2_q  <= 1'b0;
      end else if (s1_valid_i) begin
         d2_q   <= d2_d;
         r2_q   <= r2_d;
         off2_q <= off1_q;
         en2_q  <= en1_q;
      end
   end

   // S3 coverage decision
   assign in_o = en2_q & ~off2_q & (CMP_W'(d2_q) <= CMP_W'(r2_q)) & ring_ok;

endmodule

// File: rtl/draw_circles.sv
// Multi-object filled-circle renderer for a VGA pixel stream. Holds the
// frame-synchronous shadow copies of the object parameters, one distance
// pipeline per object, the lowest-index priority select and the per-frame
// "drawn" accumulator. Optional macro DRAW_CIRCLES_RING_EN draws rings of
// width RING_W instead of filled disks.
module draw_circles
   import draw_pkg::*;
#(
   parameter int                 N_OBJ         = 4,
   parameter int                 COORD_W       = 11,
   parameter int                 RADIUS_W      = 7,
   parameter int                 COLOR_W       = 12,
   parameter logic [COLOR_W-1:0] DEFAULT_COLOR = COLOR_W'(DEFAULT_SCORE_COLOR)
`ifdef DRAW_CIRCLES_RING_EN
   ,
   parameter int                 RING_W        = 3
`endif
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_start,
   input  logic                         pix_valid,
   input  logic [COORD_W-1:0]           x,
   input  logic [COORD_W-1:0]           y,
   input  logic                         mode,
   input  logic [N_OBJ*COORD_W-1:0]     obj_x,
   input  logic [N_OBJ*COORD_W-1:0]     obj_y,
   input  logic [N_OBJ*RADIUS_W-1:0]    obj_r,
   input  logic [N_OBJ*COLOR_W-1:0]     obj_color,
   input  logic [N_OBJ-1:0]             obj_en,
   output logic                         color_valid,
   output logic [COLOR_W-1:0]           color,
   output logic                         hit,
   output logic [clog2_min1(N_OBJ)-1:0] hit_idx,
   output logic [N_OBJ-1:0]             obj_drawn
);

   localparam int HIT_W = clog2_min1(N_OBJ);

   logic [N_OBJ*COORD_W-1:0]  sh_x_q, sh_y_q, eff_x, eff_y;
   logic [N_OBJ*RADIUS_W-1:0] sh_r_q, eff_r;
   logic [N_OBJ*COLOR_W-1:0]  sh_color_q;
   logic [N_OBJ-1:0]          sh_en_q, eff_en;
   logic                      v1_q, v2_q, mode1_q, mode2_q;
   logic [N_OBJ-1:0]          in_vec, hit_vec, acc_q, obj_drawn_q;
   logic                      win_d;
   logic [HIT_W-1:0]          win_idx_d, hit_idx_q;
   logic [COLOR_W-1:0]        win_color_d, color_d, color_q;
   logic                      hit_q, color_valid_q;

   // Shadow copy of the object table, reloaded only at the frame boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_x_q     <= '0;
         sh_y_q     <= '0;
         sh_r_q     <= '0;
         sh_color_q <= '0;
         sh_en_q    <= '0;
      end else if (frame_start) begin
         sh_x_q     <= obj_x;
         sh_y_q     <= obj_y;
         sh_r_q     <= obj_r;
         sh_color_q <= obj_color;
         sh_en_q    <= obj_en;
      end
   end

   // A pixel arriving with frame_start already sees the new table
   assign eff_x  = frame_start ? obj_x  : sh_x_q;
   assign eff_y  = frame_start ? obj_y  : sh_y_q;
   assign eff_r  = frame_start ? obj_r  : sh_r_q;
   assign eff_en = frame_start ? obj_en : sh_en_q;

   // Valid and mode travel alongside the pixel through S1/S2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         mode1_q <= 1'b0;
         mode2_q <= 1'b0;
      end else begin
         v1_q <= pix_valid;
         v2_q <= v1_q;
         if (pix_valid) mode1_q <= mode;
         if (v1_q)      mode2_q <= mode1_q;
      end
   end

   for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
      circle_hit_pipe #(
         .COORD_W  (COORD_W),
         .RADIUS_W (RADIUS_W)
`ifdef DRAW_CIRCLES_RING_EN
         ,
         .RING_W   (RING_W)
`endif
      ) u_pipe (
         .clk        (clk),
         .rst        (rst),
         .s0_valid_i (pix_valid),
         .s1_valid_i (v1_q),
         .x_i        (x),
         .y_i        (y),
         .ox_i       (eff_x[slice_lsb(i, COORD_W) +: COORD_W]),
         .oy_i       (eff_y[slice_lsb(i, COORD_W) +: COORD_W]),
         .r_i        (eff_r[slice_lsb(i, RADIUS_W) +: RADIUS_W]),
         .en_i       (eff_en[i]),
         .in_o       (in_vec[i])
      );
   end

   assign hit_vec = in_vec & {N_OBJ{v2_q}};

   // Lowest-index covering object wins; scan downward so it overwrites last.
   // Colours come from the shadow table, which is stable for the whole frame.
   always_comb begin
      win_d       = 1'b0;
      win_idx_d   = '0;
      win_color_d = '0;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (in_vec[i]) begin
            win_d       = 1'b1;
            win_idx_d   = HIT_W'(i);
            win_color_d = sh_color_q[slice_lsb(i, COLOR_W) +: COLOR_W];
         end
      end
      if (!win_d)                     color_d = COLOR_W'(NULL_COLOR);
      else if (mode2_q == MODE_LIMITED) color_d = win_color_d;
      else                            color_d = DEFAULT_COLOR;
   end

   // S3 output register; data holds while no valid pixel completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         color_valid_q <= 1'b0;
         color_q       <= '0;
         hit_q         <= 1'b0;
         hit_idx_q     <= '0;
      end else begin
         color_valid_q <= v2_q;
         if (v2_q) begin
            color_q   <= color_d;
            hit_q     <= win_d;
            hit_idx_q <= win_idx_d;
         end
      end
   end

   // Per-frame coverage accumulator, published and cleared at frame_start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         obj_drawn_q <= '0;
      end else if (frame_start) begin
         obj_drawn_q <= acc_q | hit_vec;
         acc_q       <= '0;
      end else begin
         acc_q <= acc_q | hit_vec;
      end
   end

   assign color_valid = color_valid_q;
   assign color       = color_q;
   assign hit         = hit_q;
   assign hit_idx     = hit_idx_q;
   assign obj_drawn   = obj_drawn_q;

endmodule

// File: tb/tb_draw_circles.sv
// Directed self-checking bench for draw_circles (default build, filled disks).
module tb_draw_circles;

   localparam int N  = 4;
   localparam int CW = 11;
   localparam int RW = 7;
   localparam int KW = 12;
   localparam int HW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            frame_start, pix_valid, mode;
   logic [CW-1:0]   x, y;
   logic [N*CW-1:0] obj_x, obj_y;
   logic [N*RW-1:0] obj_r;
   logic [N*KW-1:0] obj_color;
   logic [N-1:0]    obj_en;
   logic            color_valid, hit;
   logic [KW-1:0]   color;
   logic [HW-1:0]   hit_idx;
   logic [N-1:0]    obj_drawn;

   int tests = 0;
   int fails = 0;

   draw_circles dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .x           (x),
      .y           (y),
      .mode        (mode),
      .obj_x       (obj_x),
      .obj_y       (obj_y),
      .obj_r       (obj_r),
      .obj_color   (obj_color),
      .obj_en      (obj_en),
      .color_valid (color_valid),
      .color       (color),
      .hit         (hit),
      .hit_idx     (hit_idx),
      .obj_drawn   (obj_drawn)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_obj(input int i, input int ox, input int oy, input int r,
                          input int col, input logic en);
      obj_x[i*CW +: CW]     = CW'(ox);
      obj_y[i*CW +: CW]     = CW'(oy);
      obj_r[i*RW +: RW]     = RW'(r);
      obj_color[i*KW +: KW] = KW'(col);
      obj_en[i]             = en;
   endtask

   // Pulse frame_start, optionally with a pixel in the same cycle
   task automatic frame(input logic with_pix, input int px, input int py);
      @(negedge clk);
      frame_start = 1'b1;
      pix_valid   = with_pix;
      x           = CW'(px);
      y           = CW'(py);
      @(negedge clk);
      frame_start = 1'b0;
      pix_valid   = 1'b0;
   endtask

   task automatic pixel(input int px, input int py);
      @(negedge clk);
      pix_valid = 1'b1;
      x         = CW'(px);
      y         = CW'(py);
      @(negedge clk);
      pix_valid = 1'b0;
   endtask

   // Result appears three cycles after the pixel was presented
   task automatic expect_px(input string tag, input logic exp_hit, input int exp_idx,
                            input int exp_col);
      @(negedge clk);
      @(negedge clk);
      check({tag, ".valid"}, color_valid, 1);
      check({tag, ".hit"}, hit, exp_hit);
      check({tag, ".color"}, color, exp_col);
      if (exp_hit) check({tag, ".idx"}, hit_idx, exp_idx);
   endtask

   initial begin
      rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; mode = 1'b1;
      x = '0; y = '0;
      obj_x = '0; obj_y = '0; obj_r = '0; obj_color = '0; obj_en = '0;
      repeat (3) @(negedge clk);
      check("rst.color", color, 0);
      check("rst.valid", color_valid, 0);
      check("rst.hit", hit, 0);
      check("rst.idx", hit_idx, 0);
      check("rst.drawn", obj_drawn, 0);
      rst = 1'b0;

      // Frame 1: obj0 disk r=10, obj1 single-pixel r=0
      set_obj(0, 100, 100, 10, 12'h0F0, 1'b1);
      set_obj(1, 300, 300, 0, 12'h00F, 1'b1);
      set_obj(2, 0, 0, 0, 0, 1'b0);
      set_obj(3, 0, 0, 0, 0, 1'b0);
      frame(1'b0, 0, 0);
      check("f1.drawn", obj_drawn, 4'b0000);
      pixel(106, 108);                          // d2 = 100 = r2
      expect_px("edge_in", 1'b1, 0, 12'h0F0);
      @(negedge clk);
      check("hold.valid", color_valid, 0);
      check("hold.color", color, 12'h0F0);
      pixel(107, 108);                          // d2 = 113
      expect_px("edge_out", 1'b0, 0, 0);
      pixel(11'h464, 100);                      // low bits at the centre, MSB set
      expect_px("offscreen", 1'b0, 0, 0);
      pixel(300, 300);
      expect_px("r0_centre", 1'b1, 1, 12'h00F);
      pixel(301, 300);
      expect_px("r0_next", 1'b0, 0, 0);

      // Moving obj0 without frame_start must not affect drawing
      obj_x[0*CW +: CW] = CW'(500);
      pixel(106, 108);
      expect_px("shadow_old", 1'b1, 0, 12'h0F0);

      // Frame 2: new position visible from the frame_start cycle itself
      frame(1'b1, 500, 100);
      expect_px("bypass", 1'b1, 0, 12'h0F0);
      check("f2.drawn", obj_drawn, 4'b0011);
      pixel(106, 108);
      expect_px("shadow_moved", 1'b0, 0, 0);

      // Frame 3: obj0 and obj2 overlap at (200,50)
      set_obj(0, 200, 50, 5, 12'h111, 1'b1);
      set_obj(1, 300, 300, 0, 12'h00F, 1'b0);
      set_obj(2, 202, 50, 5, 12'h222, 1'b1);
      frame(1'b0, 0, 0);
      check("f3.drawn", obj_drawn, 4'b0001);
      pixel(200, 50);
      expect_px("prio0", 1'b1, 0, 12'h111);
      mode = 1'b0;
      pixel(200, 50);
      expect_px("default_col", 1'b1, 0, 12'hF80);
      mode = 1'b1;

      // Frame 4: obj0 disabled, obj2 wins; obj1 moved to (10,10) r=3
      set_obj(0, 200, 50, 5, 12'h111, 1'b0);
      set_obj(1, 10, 10, 3, 12'h0AA, 1'b1);
      frame(1'b0, 0, 0);
      check("f4.drawn", obj_drawn, 4'b0101);
      pixel(200, 50);
      expect_px("prio2", 1'b1, 2, 12'h222);

      // Frame 5 (frame A): only obj1 is hit
      frame(1'b0, 0, 0);
      check("f5.drawn", obj_drawn, 4'b0100);
      pixel(10, 11);
      expect_px("obj1", 1'b1, 1, 12'h0AA);
      frame(1'b0, 0, 0);
      check("f6.drawn", obj_drawn, 4'b0010);
      frame(1'b0, 0, 0);                        // after an empty frame
      check("f7.drawn", obj_drawn, 4'b0000);
      pixel(10, 11);
      expect_px("f7.obj1", 1'b1, 1, 12'h0AA);
      frame(1'b0, 0, 0);
      check("f8.drawn", obj_drawn, 4'b0010);

      // Reset with two pixels in flight
      @(negedge clk);
      pix_valid = 1'b1; x = CW'(10); y = CW'(11);
      @(negedge clk);
      @(negedge clk);
      pix_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rst.drawn", obj_drawn, 0);
      check("mid_rst.valid", color_valid, 0);
      @(negedge clk);
      check("mid_rst.valid1", color_valid, 0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst.valid2", color_valid, 0);
      @(negedge clk);
      check("mid_rst.valid3", color_valid, 0);
      check("mid_rst.drawn2", obj_drawn, 0);

      // Shadows are empty until the next frame_start
      pixel(10, 11);
      expect_px("post_rst", 1'b0, 0, 0);
      frame(1'b0, 0, 0);
      check("f9.drawn", obj_drawn, 4'b0000);
      pixel(10, 11);
      expect_px("f9.obj1", 1'b1, 1, 12'h0AA);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/draw_circles.md
Name: draw_circles

Overview:
Parametrised successor to the single-score renderer. It draws up to N_OBJ filled circles, each with its own position, radius, colour and enable, into the VGA pixel stream. The distance test is pipelined per object, and overlapping circles are resolved by fixed priority. Object parameters are double-buffered at frame boundaries, and a per-frame "drawn" flag is reported for each object for game logic (e.g. scoring when a target is visible).

Parameters:
N_OBJ, 4, number of circle objects (1..8)
COORD_W, 11, coordinate width; MSB=1 marks an off-screen/blank coordinate
RADIUS_W, 7, radius width (unsigned)
COLOR_W, 12, RGB colour width
DEFAULT_COLOR, 12'hF80, colour used when mode is not LIMITED

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
frame_start  in  1  one-cycle pulse at frame boundary (during blanking)
pix_valid  in  1  x/y valid this cycle
x  in  COORD_W  pixel column
y  in  COORD_W  pixel row
mode  in  1  1=LIMITED (per-object colour), 0=DEFAULT_COLOR
obj_x  in  N_OBJ*COORD_W  object centre x, object i at [i*COORD_W +: COORD_W]
obj_y  in  N_OBJ*COORD_W  object centre y
obj_r  in  N_OBJ*RADIUS_W  object radius
obj_color  in  N_OBJ*COLOR_W  object colour
obj_en  in  N_OBJ  object enable
color_valid  out  1  color/hit_idx valid
color  out  COLOR_W  output colour; NULL (0) when no object is hit
hit  out  1  some object covers this pixel
hit_idx  out  clog2(N_OBJ) (min 1)  index of the winning object
obj_drawn  out  N_OBJ  per-object "covered at least one pixel last frame"

Behaviour:
- Reset (asynchronous, rst=1):
  - color=0, color_valid=0, hit=0, hit_idx=0, obj_drawn=0.
  - Shadow object registers and the drawn accumulator are cleared; shadow enables = 0.
- Shadowing:
  - On frame_start, obj_x/y/r/color/en are copied into shadow registers. Only the shadow values are used for drawing.
  - A pixel presented in the same cycle as frame_start uses the new shadow values (bypass).
- Pipeline: 3 stages, fixed latency 3. color_valid is pix_valid delayed 3 cycles. No stalls.
  - S1: dx = x[COORD_W-2:0] - ox[COORD_W-2:0] and dy = y[COORD_W-2:0] - oy[COORD_W-2:0], both signed COORD_W bits. An off-screen flag (x or y MSB set) is carried along.
  - S2: d2 = dx*dx + dy*dy, unsigned 2*COORD_W bits with no truncation; r2 = r*r.
  - S3: in_i = en_i & ~offscreen & (d2 <= r2). The winner is the lowest index with in_i=1. color = mode ? obj_color[winner] : DEFAULT_COLOR; no winner gives color=0 and hit=0.
- Per-stage data registers update only when valid. When invalid, outputs hold, but color_valid=0.
- Radius 0: only the centre pixel is drawn. A disabled object never hits.
- obj_drawn:
  - The accumulator ORs in_i for every valid S3 pixel.
  - On frame_start: obj_drawn <= acc | S3 hits of that same cycle; acc <= 0.
  - Pixels still in S1/S2 at frame_start count toward the new frame. Drivers must keep frame_start at least 3 cycles after the last visible pixel; blanking guarantees this.
- Reset mid-frame: the pipeline is flushed, nothing is drawn until the next frame_start loads the shadows, and obj_drawn stays 0.

Optional Feature:
DRAW_CIRCLES_RING_EN
- Defined: adds parameter RING_W (default 3). An object hits only when d2 <= r2 and d2 > (r-RING_W)^2. If r <= RING_W, the object is treated as a filled disk. The extra square is computed in S2, so latency stays 3.
- Undefined: filled disks only; the parameter and logic are absent.

Decomposition:
- Shared package draw_pkg holds:
  - NULL colour (0) and the LIMITED mode encoding (1)
  - DEFAULT score colour
  - the clog2 width helper
  - the flat-bus slice helpers
- Natural sub-module: circle_hit_pipe, a single-object S1–S2 distance/compare pipeline, instantiated N_OBJ times. The top level holds the shadows, the priority select and the drawn accumulator.

Test Plan:
- Edge of circle: frame_start loads obj0=(100,100), r=10, en=1, mode=1, color=12'h0F0. Pixel (106,108) gives d2=100 → three cycles later color=0F0, hit=1, hit_idx=0. Pixel (107,108) gives d2=113 → color=0, hit=0.
- Priority: obj0 and obj2 both cover (200,50) → hit_idx=0 with obj0's colour. With obj0 disabled → hit_idx=2. With mode=0 → color=F80.
- Off-screen: pixel x=11'h464 (MSB set, low bits inside the circle) → color=0, hit=0.
- Shadowing: obj_x changes mid-frame with no frame_start → drawing is unchanged. After the next frame_start → the new position is drawn, including a pixel in the frame_start cycle itself.
- Drawn flags and reset: only obj1 is hit during frame A → at the next frame_start obj_drawn=4'b0010. Then an empty frame → 4'b0000. Assert rst with 2 pixels in flight → color_valid stays 0 and obj_drawn=0 immediately.
- Ring build (DRAW_CIRCLES_RING_EN, RING_W=3, r=10): d2=100 → hit; d2=49 → no hit; with r=2, d2=0 → hit.
